// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler: per-timestep frame/enable/settle/tick sequencer with spike counting; ZERO_PAD_EN pads an empty FIFO with a zero frame
module snn_timestep_scheduler #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int CW            = 8
) (
    input  logic          system_clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    num_steps,
    input  logic          frame_valid,
    output logic          frame_ready,
    input  logic [23:0]   frame_data,
    output logic [23:0]   snn_input_spikes,
    output logic          snn_enable,
    output logic          delay_tick,
    input  logic [1:0]    snn_output_spikes,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [CW-1:0] spike_count0,
    output logic [CW-1:0] spike_count1
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, SETTLE, TICK, DONE} state_t;
    state_t state, state_nx;
    logic [23:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] used;
    logic alive, empty, push, pop;
    logic [7:0] steps, step_cnt;
    logic [SW-1:0] settle_cnt;
    assign empty        = used == '0;
    assign frame_ready  = alive && used != (AW+1)'(DEPTH);
    assign push         = frame_valid && frame_ready;
    assign pop          = state == LOAD && !empty;
    assign snn_enable   = state == FIRE;
    assign delay_tick   = state == TICK;
    assign busy         = state != IDLE;
    assign result_valid = state == DONE;
    // frame storage, written on every accepted push
    always_ff @(posedge system_clock)
        if (push) mem[wr_ptr] <= frame_data;
    // FIFO pointers and occupancy; alive holds frame_ready low until the first edge after reset
    always_ff @(posedge system_clock or negedge reset)
        if (!reset) begin
            alive  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            alive <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            used <= used + (AW+1)'(push) - (AW+1)'(pop);
        end
    // state register
    always_ff @(posedge system_clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
`ifdef ZERO_PAD_EN
            LOAD:    state_nx = FIRE;
`else
            LOAD:    if (!empty) state_nx = FIRE;
`endif
            FIRE:    state_nx = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nx = TICK;
            TICK:    state_nx = step_cnt + 8'd1 == steps ? DONE : LOAD;
            DONE:    if (result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // run datapath: step bookkeeping, frame presentation, settle timer and saturating counts
    always_ff @(posedge system_clock or negedge reset)
        if (!reset) begin
            snn_input_spikes <= '0;
            steps            <= '0;
            step_cnt         <= '0;
            settle_cnt       <= '0;
            spike_count0     <= '0;
            spike_count1     <= '0;
        end else begin
            if (state == IDLE && start) begin
                step_cnt     <= '0;
                spike_count0 <= '0;
                spike_count1 <= '0;
                steps        <= num_steps == 8'd0 ? 8'd1 : num_steps;
            end
`ifdef ZERO_PAD_EN
            if (state == LOAD) snn_input_spikes <= empty ? 24'h0 : mem[rd_ptr];
`else
            if (pop) snn_input_spikes <= mem[rd_ptr];
`endif
            if (state == FIRE) settle_cnt <= SW'(SETTLE_CYCLES);
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 1'b1;
                if (settle_cnt == '0 && snn_output_spikes[0] && !(&spike_count0)) spike_count0 <= spike_count0 + 1'b1;
                if (settle_cnt == '0 && snn_output_spikes[1] && !(&spike_count1)) spike_count1 <= spike_count1 + 1'b1;
            end
            if (state == TICK) step_cnt <= step_cnt + 8'd1;
        end
endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb_snn_timestep_scheduler: directed bench with a timeline model of the scheduler checked every cycle
module tb_snn_timestep_scheduler;
    localparam int DEPTH = 4;
    localparam int SC    = 3;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;
    logic system_clock = 1'b0;
    logic reset = 1'b0, start = 1'b0, frame_valid = 1'b0, result_ready = 1'b0;
    logic [7:0] num_steps = '0;
    logic [23:0] frame_data = '0;
    logic [1:0] echo = '0;
    logic frame_ready, snn_enable, delay_tick, busy, result_valid;
    logic [23:0] snn_input_spikes;
    logic [CW-1:0] spike_count0, spike_count1;
    int checks = 0, failures = 0, cyc = 0;
    int en_q[$], tk_q[$];
    logic [23:0] mq[$];
    logic [23:0] m_spk = '0;
    bit m_alive, m_run, m_done, do_push;
    int m_pos, m_steps, m_taken, m_c0, m_c1;

    snn_timestep_scheduler #(.DEPTH(DEPTH), .SETTLE_CYCLES(SC), .CW(CW)) dut (
        .system_clock(system_clock), .reset(reset), .start(start), .num_steps(num_steps),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .snn_input_spikes(snn_input_spikes), .snn_enable(snn_enable), .delay_tick(delay_tick),
        .snn_output_spikes(echo), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .spike_count0(spike_count0), .spike_count1(spike_count1)
    );

    always #5 system_clock = ~system_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: a step is position 0 (take frame), 1 (enable), 2..SC+2 (settle, sample at SC+2), SC+3 (tick)
    always @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_alive = 0; m_run = 0; m_done = 0; m_pos = 0; m_steps = 0; m_taken = 0;
            m_c0 = 0; m_c1 = 0; m_spk = '0;
        end else begin
            cyc++;
            do_push = frame_valid && m_alive && mq.size() < DEPTH;
            if (m_done) begin
                if (result_ready) m_done = 0;
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1; m_pos = 0; m_taken = 0; m_c0 = 0; m_c1 = 0;
                    m_steps = num_steps == 8'd0 ? 1 : int'(num_steps);
                end
            end else if (m_pos == 0) begin
                if (mq.size() > 0) begin
                    m_spk = mq.pop_front();
                    m_pos = 1;
                end
`ifdef ZERO_PAD_EN
                else begin
                    m_spk = '0;
                    m_pos = 1;
                end
`endif
            end else if (m_pos == SC + 3) begin
                m_taken++;
                m_pos = 0;
                if (m_taken == m_steps) begin
                    m_run = 0;
                    m_done = 1;
                end
            end else begin
                if (m_pos == SC + 2) begin
                    m_c0 = m_c0 + int'(echo[0]) > MAXC ? MAXC : m_c0 + int'(echo[0]);
                    m_c1 = m_c1 + int'(echo[1]) > MAXC ? MAXC : m_c1 + int'(echo[1]);
                end
                m_pos++;
            end
            if (do_push) mq.push_back(frame_data);
            m_alive = 1;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge system_clock) begin
        check("frame_ready", 32'(frame_ready), 32'(m_alive && mq.size() < DEPTH));
        check("snn_enable", 32'(snn_enable), 32'(m_run && m_pos == 1));
        check("delay_tick", 32'(delay_tick), 32'(m_run && m_pos == SC + 3));
        check("busy", 32'(busy), 32'(m_run || m_done));
        check("result_valid", 32'(result_valid), 32'(m_done));
        check("snn_input_spikes", 32'(snn_input_spikes), 32'(m_spk));
        check("spike_count0", 32'(spike_count0), m_c0);
        check("spike_count1", 32'(spike_count1), m_c1);
        check("enable_tick_overlap", 32'(snn_enable & delay_tick), 32'(0));
        if (snn_enable) en_q.push_back(cyc);
        if (delay_tick) tk_q.push_back(cyc);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge system_clock);
            #1;
        end
    endtask

    task automatic push1(input logic [23:0] d);
        frame_valid = 1'b1;
        frame_data = d;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] n);
        num_steps = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic wait_rv(input int bound, input string name);
        int n = 0;
        while (!result_valid && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (!result_valid) begin
            failures++;
            $display("FAIL %s: result_valid not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_model(input int pos, input int taken, input string name);
        int n = 0;
        while (!(m_run && m_pos == pos && m_taken == taken) && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(m_run && m_pos == pos), 32'(1));
    endtask

    initial begin : main
        int n;
        // 1: reset held with a frame offered
        frame_valid = 1'b1;
        frame_data = 24'hAAAAAA;
        step(3);
        check("rst_frame_ready", 32'(frame_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_spikes", 32'(snn_input_spikes), 32'(0));
        check("rst_counts", 32'({spike_count1, spike_count0}), 32'(0));
        reset = 1'b1;
        frame_valid = 1'b0;
        step();
        check("release_frame_ready", 32'(frame_ready), 32'(1));
        // 2: three-step run echoing neuron 0
        push1(24'h000001);
        push1(24'h000002);
        push1(24'h000003);
        echo = 2'b01;
        en_q.delete();
        tk_q.delete();
        run(8'd3);
        wait_rv(100, "run3_done");
        check("run3_enables", en_q.size(), 3);
        check("run3_ticks", tk_q.size(), 3);
        check("run3_en_gap1", en_q[1] - en_q[0], 7);
        check("run3_en_gap2", en_q[2] - en_q[1], 7);
        check("run3_tk_gap1", tk_q[1] - tk_q[0], 7);
        check("run3_tk_gap2", tk_q[2] - tk_q[1], 7);
        step(3);
        check("run3_rv_held", 32'(result_valid), 32'(1));
        check("run3_count0", 32'(spike_count0), 32'(3));
        check("run3_count1", 32'(spike_count1), 32'(0));
        accept();
        check("run3_rv_cleared", 32'(result_valid), 32'(0));
        // 3: fill the FIFO, then push and pop in the same cycle during a run
        frame_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            frame_data = 24'h000010 + 24'(i);
            step();
        end
        check("full_frame_ready", 32'(frame_ready), 32'(0));
        frame_data = 24'h000BAD;
        step();
        frame_valid = 1'b0;
        echo = 2'b10;
        run(8'd4);
        wait_model(0, 1, "reach_second_load");
        frame_valid = 1'b1;
        frame_data = 24'h00AA55;
        step();
        frame_valid = 1'b0;
        wait_rv(100, "run4_done");
        accept();
        n = 0;
        frame_valid = 1'b1;
        while (frame_ready && n < 10) begin
            frame_data = 24'h000030 + 24'(n);
            step();
            n++;
        end
        frame_valid = 1'b0;
        check("pushes_to_full", n, 3);
        en_q.delete();
        run(8'd0);
        wait_rv(60, "run0_done");
        check("run0_enables", en_q.size(), 1);
        accept();
        run(8'd3);
        wait_rv(100, "drain_done");
        accept();
        // 4: underflow with one queued frame
        echo = 2'b11;
        push1(24'h0000F0);
        en_q.delete();
        run(8'd2);
        step(20);
`ifdef ZERO_PAD_EN
        check("pad_enables", en_q.size(), 2);
        check("pad_done", 32'(result_valid), 32'(1));
        check("pad_zero_frame", 32'(snn_input_spikes), 32'(0));
        accept();
        push1(24'h00000F);
`else
        check("stall_enables", en_q.size(), 1);
        check("stall_busy", 32'(busy), 32'(1));
        check("stall_no_result", 32'(result_valid), 32'(0));
        push1(24'h00000F);
        wait_rv(60, "stall_resume");
        check("stall_resume_enables", en_q.size(), 2);
        check("stall_frame", 32'(snn_input_spikes), 32'(24'h00000F));
        check("stall_counts", 32'({spike_count1, spike_count0}), 32'({2'd2, 2'd2}));
        accept();
`endif
        // 5: saturation at CW=2 over five steps, frames offered continuously
        echo = 2'b11;
        frame_valid = 1'b1;
        frame_data = 24'h555555;
        en_q.delete();
        run(8'd5);
        wait_rv(200, "sat_done");
        frame_valid = 1'b0;
        check("sat_enables", en_q.size(), 5);
        check("sat_count0", 32'(spike_count0), 32'(3));
        check("sat_count1", 32'(spike_count1), 32'(3));
        accept();
        // 6: reset in the middle of a settle window
        echo = 2'b01;
        run(8'd2);
        wait_model(SC, 0, "reach_settle");
        tk_q.delete();
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_tick", 32'(delay_tick), 32'(0));
        check("midrst_counts", 32'({spike_count1, spike_count0}), 32'(0));
        step(2);
        reset = 1'b1;
        step();
        check("midrst_no_ticks", tk_q.size(), 0);
        check("midrst_ready", 32'(frame_ready), 32'(1));
        en_q.delete();
        run(8'd1);
        step(15);
`ifdef ZERO_PAD_EN
        check("midrst_fifo_empty", 32'(snn_input_spikes), 32'(0));
`else
        check("midrst_fifo_empty", en_q.size(), 0);
        push1(24'h000007);
`endif
        wait_rv(60, "final_done");
        start = 1'b1;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        step();
        check("start_in_done_ignored", 32'(busy), 32'(0));
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
